// File: rtl/pmips_pkg.sv
// Shared opcode and branch-predictor constants for the PMIPS 16-bit pipeline.
package pmips_pkg;

  localparam logic [2:0] OP_J   = 3'd1;
  localparam logic [2:0] OP_JAL = 3'd7;
  localparam logic [2:0] OP_BR  = 3'b100;

  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;

  localparam logic [2:0] LINK_REG = 3'd7;

endpackage

// File: rtl/pmips_bimodal_pred.sv
// Bimodal branch predictor: 2-bit saturating counters, combinational read,
// synchronous update from branch resolution.
module pmips_bimodal_pred
  import pmips_pkg::*;
#(
  parameter int unsigned PRED_DEPTH = 64,
  parameter int unsigned AW         = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [AW-1:0] rd_pc_i,
  output logic          rd_taken_o,
  input  logic          upd_valid_i,
  input  logic [AW-1:0] upd_pc_i,
  input  logic          upd_taken_i
);

  localparam int unsigned IW = $clog2(PRED_DEPTH);

  logic [1:0]    ctr_q [PRED_DEPTH];
  logic [IW-1:0] rd_idx;
  logic [IW-1:0] upd_idx;
  logic [1:0]    upd_old;
  logic [1:0]    upd_new;
  logic          unused_pc_bits;

  // Instructions are halfword aligned, so bit 0 never selects an entry.
  assign rd_idx         = rd_pc_i[IW:1];
  assign upd_idx        = upd_pc_i[IW:1];
  assign unused_pc_bits = ^{rd_pc_i[0], upd_pc_i[0], rd_pc_i[AW-1:IW+1], upd_pc_i[AW-1:IW+1]};

  assign rd_taken_o = ctr_q[rd_idx][1];
  assign upd_old    = ctr_q[upd_idx];

  always_comb begin
    upd_new = upd_old;
    if (upd_taken_i) begin
      if (upd_old != ST) upd_new = upd_old + 2'd1;
    end else begin
      if (upd_old != SNT) upd_new = upd_old - 2'd1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      for (int unsigned i = 0; i < PRED_DEPTH; i++) ctr_q[i] <= WNT;
    end else if (upd_valid_i) begin
      ctr_q[upd_idx] <= upd_new;
    end
  end

endmodule

// File: rtl/pmips_fetch.sv
// PMIPS instruction-fetch stage: PC, next-PC selection, IF/ID register,
// optional bimodal prediction and a saturating mispredict counter.
module pmips_fetch
  import pmips_pkg::*;
#(
  parameter int unsigned   AW         = 16,
  parameter logic [AW-1:0] RESET_PC   = '0,
  parameter int unsigned   PRED_MODE  = 1,
  parameter int unsigned   PRED_DEPTH = 64,
  parameter int unsigned   CNT_W      = 16,
  parameter logic [2:0]    BR_OPCODE  = OP_BR
) (
  input  logic             clock,
  input  logic             reset,
  output logic [AW-1:0]    imem_addr,
  input  logic [15:0]      imem_rdata,
  input  logic             stall,
  input  logic             res_valid,
  input  logic [AW-1:0]    res_pc,
  input  logic             res_taken,
  input  logic [AW-1:0]    res_target,
  input  logic             res_pred_taken,
  output logic             flush,
  output logic             ifid_valid,
  output logic [15:0]      ifid_instr,
  output logic [AW-1:0]    ifid_pc,
  output logic [AW-1:0]    ifid_pcplus2,
  output logic             ifid_pred_taken,
  output logic [CNT_W-1:0] mispredict_count
);

  logic [AW-1:0]    pc_q, pc_d, pc_plus2, jump_tgt, br_tgt;
  logic [2:0]       opcode;
  logic             is_jump, is_br, pred_raw, pred_taken, mispredict;
  logic             ifid_valid_q, ifid_pred_q;
  logic [15:0]      ifid_instr_q;
  logic [AW-1:0]    ifid_pc_q, ifid_pcplus2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign opcode     = imem_rdata[15:13];
  assign is_jump    = (opcode == OP_J) || (opcode == OP_JAL);
  assign is_br      = (opcode == BR_OPCODE);
  assign pc_plus2   = pc_q + AW'(2);
  assign jump_tgt   = AW'($signed(imem_rdata[12:0]));
  assign br_tgt     = pc_plus2 + AW'($signed({imem_rdata[6:0], 1'b0}));
  assign pred_taken = is_br & pred_raw;
  assign mispredict = res_valid & (res_taken != res_pred_taken);
  assign flush      = mispredict & ~reset;

  if (PRED_MODE != 0) begin : g_pred
    pmips_bimodal_pred #(
      .PRED_DEPTH(PRED_DEPTH),
      .AW        (AW)
    ) u_pred (
      .clock      (clock),
      .reset      (reset),
      .rd_pc_i    (pc_q),
      .rd_taken_o (pred_raw),
      .upd_valid_i(res_valid),
      .upd_pc_i   (res_pc),
      .upd_taken_i(res_taken)
    );
  end else begin : g_static
    assign pred_raw = 1'b0;
  end

  // A redirect from branch resolution must override a load-use stall.
  always_comb begin
    pc_d = pc_plus2;
    if (reset)           pc_d = RESET_PC;
    else if (mispredict) pc_d = res_taken ? res_target : res_pc + AW'(2);
    else if (stall)      pc_d = pc_q;
    else if (is_jump)    pc_d = jump_tgt;
    else if (pred_taken) pc_d = br_tgt;
  end

  always_comb begin
    cnt_d = cnt_q;
    if (mispredict && (cnt_q != '1)) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clock) begin
    pc_q <= pc_d;
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  always_ff @(posedge clock) begin
    if (reset || mispredict) begin
      ifid_valid_q   <= 1'b0;
      ifid_instr_q   <= '0;
      ifid_pc_q      <= '0;
      ifid_pcplus2_q <= '0;
      ifid_pred_q    <= 1'b0;
    end else if (!stall) begin
      ifid_valid_q   <= 1'b1;
      ifid_instr_q   <= imem_rdata;
      ifid_pc_q      <= pc_q;
      ifid_pcplus2_q <= pc_plus2;
      ifid_pred_q    <= pred_taken;
    end
  end

  assign imem_addr        = pc_q;
  assign ifid_valid       = ifid_valid_q;
  assign ifid_instr       = ifid_instr_q;
  assign ifid_pc          = ifid_pc_q;
  assign ifid_pcplus2     = ifid_pcplus2_q;
  assign ifid_pred_taken  = ifid_pred_q;
  assign mispredict_count = cnt_q;

endmodule
